// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared sizes and state encoding for the note RAM sequencer
package note_seq_pkg;

  localparam int DEPTH  = 64;
  localparam int NOTE_W = 32;

  // Encoding is shown on the HEX5 debug digit, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC       = 3'd1,
    S_PLAY      = 3'd2,
    S_PLAY_WAIT = 3'd3,
    S_PLAY_OUT  = 3'd4,
    S_DONE      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/note_window_accum.sv
// rtl/note_window_accum.sv - OR-accumulates note vectors over one tempo window
module note_window_accum
  import note_seq_pkg::*;
#(
  parameter int W = NOTE_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] note_in,
  output logic [W-1:0] window
);

  logic [W-1:0] accum_q;

  // Includes the current cycle so a note present on the tick itself is kept.
  assign window = accum_q | note_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      accum_q <= '0;
    end else if (!en || clr) begin
      accum_q <= '0;
    end else begin
      accum_q <= window;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - record/playback sequencer for the 64x32 note RAM
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = NOTE_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_rec,
  input  logic              mode_play,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] note_in,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [DATA_W-1:0] note_out,
  output logic              note_vld,
  output logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(2 ** ADDR_W - 1);
  localparam logic [ADDR_W:0] FULL_LEN  = (ADDR_W + 1)'(2 ** ADDR_W);

  seq_state_e        state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [ADDR_W:0]   length_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_wren_q;
  logic [DATA_W-1:0] note_out_q;
  logic              note_vld_q;
  logic [DATA_W-1:0] window;

  note_window_accum #(.W(DATA_W)) u_accum (
    .clk     (clk),
    .resetn  (resetn),
    .en      (state_q == S_REC),
    .clr     (tick),
    .note_in (note_in),
    .window  (window)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      length_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      note_out_q <= '0;
      note_vld_q <= 1'b0;
    end else begin
      ram_wren_q <= 1'b0;
      note_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && mode_rec && !mode_play) begin
            wr_ptr_q <= '0;
            state_q  <= S_REC;
          end else if (start && mode_play && !mode_rec) begin
            rd_ptr_q <= '0;
            state_q  <= (length_q == '0) ? S_DONE : S_PLAY;
          end
        end
        S_REC: begin
          // A tick coinciding with stop still commits its word.
          if (tick) begin
            ram_addr_q <= wr_ptr_q[ADDR_W-1:0];
            ram_data_q <= window;
            ram_wren_q <= 1'b1;
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              length_q <= FULL_LEN;
              state_q  <= S_DONE;
            end else if (stop) begin
              length_q <= wr_ptr_q + 1'b1;
              state_q  <= S_DONE;
            end
          end else if (stop) begin
            length_q <= wr_ptr_q;
            state_q  <= S_DONE;
          end
        end
        S_PLAY: begin
          if (stop) begin
            state_q <= S_DONE;
          end else if (tick) begin
            ram_addr_q <= rd_ptr_q[ADDR_W-1:0];
            state_q    <= S_PLAY_WAIT;
          end
        end
        S_PLAY_WAIT: begin
          state_q <= stop ? S_DONE : S_PLAY_OUT;
        end
        S_PLAY_OUT: begin
          if (stop) begin
            state_q <= S_DONE;
          end else begin
            note_out_q <= ram_q;
            note_vld_q <= 1'b1;
            if (rd_ptr_q + 1'b1 == length_q) begin
              rd_ptr_q <= '0;
              state_q  <= loop_en ? S_PLAY : S_DONE;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              state_q  <= S_PLAY;
            end
          end
        end
        S_DONE: begin
          note_out_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign note_out = note_out_q;
  assign note_vld = note_vld_q;
  assign length   = length_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        resetn, tick, start, stop, mode_rec, mode_play, loop_en;
  logic [31:0] note_in, ram_q, ram_data, note_out;
  logic [5:0]  ram_addr;
  logic        ram_wren, note_vld, busy, done;
  logic [6:0]  length;
  logic [2:0]  state;

  logic [31:0] mem [64];
  int          wr_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] vals [3];

  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle synchronous read, write on ram_wren.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      wr_cnt <= wr_cnt + 1;
    end
    ram_q <= mem[ram_addr];
  end

  note_sequencer dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .stop(stop),
    .mode_rec(mode_rec), .mode_play(mode_play), .loop_en(loop_en),
    .note_in(note_in), .ram_q(ram_q), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .note_out(note_out), .note_vld(note_vld),
    .length(length), .busy(busy), .done(done), .state(state)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick = 0; start = 0; stop = 0; mode_rec = 0; mode_play = 0;
    loop_en = 0; note_in = '0;
    cyc(3);
    checks++;
    if ({state, busy, done, ram_wren, note_vld} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {state, busy, done, ram_wren, note_vld});
    end
    checks++;
    if ({length, ram_addr, ram_data, note_out} !== '0) begin
      failures++; $display("FAIL reset_data len=%0d addr=%0d data=%0h note=%0h exp=0", length, ram_addr, ram_data, note_out);
    end
    resetn = 1'b1;
    cyc(1);
    mode_rec = 1; mode_play = 1;
    pulse_start();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL both_modes_start got=%0d exp=0", state); end
    mode_rec = 0; mode_play = 0;
    pulse_start();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL no_mode_start got=%0d exp=0", state); end
  endtask

  task automatic test_rec_basic();
    mode_rec = 1;
    pulse_start();
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL rec_enter state=%0d busy=%b exp=1/1", state, busy); end
    for (int i = 0; i < 3; i++) begin
      note_in = vals[i];
      cyc(3);
      pulse_tick();
      checks++;
      if ({ram_wren, ram_addr, ram_data} !== {1'b1, 6'(i), vals[i]}) begin
        failures++; $display("FAIL rec_write%0d wren=%b addr=%0d data=%0h exp=1/%0d/%0h", i, ram_wren, ram_addr, ram_data, i, vals[i]);
      end
    end
    note_in = '0;
    cyc(2);
    pulse_stop();
    checks++;
    if (state !== 3'd5 || done !== 1'b1) begin failures++; $display("FAIL rec_stop_done state=%0d done=%b exp=5/1", state, done); end
    cyc(1);
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || length !== 7'd3) begin
      failures++; $display("FAIL rec_len state=%0d done=%b len=%0d exp=0/0/3", state, done, length);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[i] !== vals[i]) begin failures++; $display("FAIL rec_ram%0d got=%0h exp=%0h", i, mem[i], vals[i]); end
    end
    mode_rec = 0;
  endtask

  task automatic test_play_once();
    loop_en = 0; mode_play = 1;
    pulse_start();
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL play_enter got=%0d exp=2", state); end
    for (int k = 0; k < 3; k++) begin
      cyc(2);
      pulse_tick();
      checks++;
      if (note_vld !== 1'b0 || state !== 3'd3) begin failures++; $display("FAIL play_t1_%0d vld=%b state=%0d exp=0/3", k, note_vld, state); end
      cyc(1);
      checks++;
      if (note_vld !== 1'b0) begin failures++; $display("FAIL play_t2_%0d vld=%b exp=0", k, note_vld); end
      cyc(1);
      checks++;
      if (note_vld !== 1'b1 || note_out !== vals[k]) begin
        failures++; $display("FAIL play_note%0d vld=%b note=%0h exp=1/%0h", k, note_vld, note_out, vals[k]);
      end
      checks++;
      if (state !== ((k == 2) ? 3'd5 : 3'd2)) begin failures++; $display("FAIL play_state%0d got=%0d exp=%0d", k, state, (k == 2) ? 5 : 2); end
    end
    cyc(1);
    checks++;
    if (note_out !== 32'h0 || state !== 3'd0 || note_vld !== 1'b0) begin
      failures++; $display("FAIL play_end note=%0h state=%0d vld=%b exp=0/0/0", note_out, state, note_vld);
    end
    pulse_tick();
    cyc(3);
    checks++;
    if (note_vld !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL play_extra_tick vld=%b state=%0d exp=0/0", note_vld, state); end
    mode_play = 0;
  endtask

  task automatic test_play_loop();
    loop_en = 1; mode_play = 1;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      cyc(2);
      pulse_tick();
      cyc(2);
      checks++;
      if (note_vld !== 1'b1 || note_out !== vals[k % 3] || state !== 3'd2) begin
        failures++; $display("FAIL loop_note%0d vld=%b note=%0h state=%0d exp=1/%0h/2", k, note_vld, note_out, state, vals[k % 3]);
      end
    end
    cyc(2);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    checks++;
    if (state !== 3'd5 || done !== 1'b1 || note_vld !== 1'b0) begin
      failures++; $display("FAIL loop_stop state=%0d done=%b vld=%b exp=5/1/0", state, done, note_vld);
    end
    cyc(1);
    checks++;
    if (note_vld !== 1'b0 || state !== 3'd0 || note_out !== 32'h0 || length !== 7'd3) begin
      failures++; $display("FAIL loop_after vld=%b state=%0d note=%0h len=%0d exp=0/0/0/3", note_vld, state, note_out, length);
    end
    loop_en = 0; mode_play = 0;
  endtask

  task automatic test_rec_or();
    int n0;
    mode_rec = 1;
    pulse_start();
    note_in = 32'h2; cyc(1); note_in = '0; cyc(2);
    note_in = 32'h4; cyc(1); note_in = '0; cyc(2);
    n0 = wr_cnt;
    pulse_tick();
    checks++;
    if ({ram_wren, ram_addr, ram_data} !== {1'b1, 6'd0, 32'h6}) begin
      failures++; $display("FAIL or_write wren=%b addr=%0d data=%0h exp=1/0/6", ram_wren, ram_addr, ram_data);
    end
    cyc(1);
    pulse_stop();
    cyc(1);
    checks++;
    if (wr_cnt !== n0 + 1 || length !== 7'd1) begin
      failures++; $display("FAIL or_count writes=%0d len=%0d exp=1/1", wr_cnt - n0, length);
    end
    mode_rec = 0;
  endtask

  task automatic test_rec_full();
    int n0;
    mode_rec = 1;
    pulse_start();
    n0 = wr_cnt;
    for (int i = 0; i < 64; i++) begin
      note_in = 32'(i * 7 + 1);
      cyc(1);
      pulse_tick();
      checks++;
      if ({ram_wren, ram_addr, ram_data} !== {1'b1, 6'(i), 32'(i * 7 + 1)}) begin
        failures++; $display("FAIL full_write%0d wren=%b addr=%0d data=%0h exp=1/%0d/%0h", i, ram_wren, ram_addr, ram_data, i, i * 7 + 1);
      end
      checks++;
      if (state !== ((i == 63) ? 3'd5 : 3'd1)) begin failures++; $display("FAIL full_state%0d got=%0d exp=%0d", i, state, (i == 63) ? 5 : 1); end
    end
    note_in = '0;
    cyc(1);
    checks++;
    if (length !== 7'd64 || state !== 3'd0) begin failures++; $display("FAIL full_len len=%0d state=%0d exp=64/0", length, state); end
    note_in = 32'hdead;
    pulse_tick(); cyc(1); pulse_tick(); cyc(2);
    checks++;
    if (wr_cnt !== n0 + 64 || mem[0] !== 32'h1) begin
      failures++; $display("FAIL full_nowrap writes=%0d ram0=%0h exp=64/1", wr_cnt - n0, mem[0]);
    end
    note_in = '0; mode_rec = 0;
  endtask

  task automatic test_reset_mid_rec();
    mode_rec = 1;
    pulse_start();
    note_in = 32'h8; cyc(1); pulse_tick();
    note_in = 32'h10; cyc(1); pulse_tick();
    checks++;
    if (ram_wren !== 1'b1 || length !== 7'd64) begin failures++; $display("FAIL mid_pre wren=%b len=%0d exp=1/64", ram_wren, length); end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({state, busy, done, ram_wren, ram_addr, ram_data, length} !== '0) begin
      failures++; $display("FAIL mid_async state=%0d busy=%b wren=%b addr=%0d data=%0h len=%0d exp=0", state, busy, ram_wren, ram_addr, ram_data, length);
    end
    @(negedge clk);
    resetn = 1'b1; mode_rec = 0; note_in = '0; mode_play = 1;
    cyc(1);
    pulse_start();
    checks++;
    if (state !== 3'd5 || done !== 1'b1) begin failures++; $display("FAIL mid_play_empty state=%0d done=%b exp=5/1", state, done); end
    cyc(1);
    checks++;
    if (state !== 3'd0 || note_vld !== 1'b0) begin failures++; $display("FAIL mid_idle state=%0d vld=%b exp=0/0", state, note_vld); end
    mode_play = 0;
  endtask

  initial begin
    vals[0] = 32'h1; vals[1] = 32'h40; vals[2] = 32'h1000;
    test_reset();
    test_rec_basic();
    test_play_once();
    test_play_loop();
    test_rec_or();
    test_rec_full();
    test_reset_mid_rec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
